modaccum_trunc_ctrl: RTL and testbench

Sequencing controller and truncation-feedback responder for the 21-bit modular accumulator at the end of the TPU modmultaccum chain. It accepts a stream of product terms from the multiplier pipeline and drives the accumulator's `load_ena`, `trunc_ena`, `in_a` and `in_b`. It answers the accumulator's `trunc_adr` with the programmed correction value `(k·2^18) mod m`. When the term count is reached it flushes the high bits, performs a final conditional subtract, and presents the fully reduced residue on a valid/ready output.

---
 rtl/modaccum_trunc_ctrl.sv | 151 +++++++++++++++
 tb/tb_modaccum_trunc_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modaccum_trunc_ctrl.sv
// Sequencing controller for the 21-bit modular accumulator: feeds product terms,
// answers trunc_adr from a programmable correction table, flushes and final-reduces.
module modaccum_trunc_ctrl #(
  parameter int MOD_W   = 18,
  parameter int TRUNC_W = 3,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MOD_W-1:0]   modulus,
  input  logic               tbl_wr_ena,
  input  logic [TRUNC_W-1:0] tbl_wr_adr,
  input  logic [MOD_W-1:0]   tbl_wr_data,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               term_valid,
  input  logic [MOD_W:0]     term_data,
  output logic               term_ready,
  output logic               acc_load_ena,
  output logic               acc_trunc_ena,
  output logic [MOD_W:0]     acc_in_a,
  output logic [MOD_W-1:0]   acc_in_b,
  input  logic [TRUNC_W-1:0] acc_trunc_adr,
  input  logic [MOD_W+2:0]   acc_result,
  output logic [MOD_W-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               err
);

  localparam int TBL_N = 1 << TRUNC_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [MOD_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [MOD_W-1:0]   tbl_q [TBL_N];
  logic [MOD_W-1:0]   tbl_d [TBL_N];

  logic [2:0]         acc_hi;
  logic [MOD_W-1:0]   acc_lo;

  assign acc_hi = acc_result[MOD_W+2:MOD_W];
  assign acc_lo = acc_result[MOD_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < TBL_N; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fcnt_d        = fcnt_q;
    result_d      = result_q;
    err_d         = err_q;
    tbl_d         = tbl_q;
    busy          = (state_q != S_IDLE);
    term_ready    = 1'b0;
    acc_load_ena  = 1'b1;
    acc_trunc_ena = 1'b0;
    acc_in_a      = '0;
    result_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tbl_wr_ena) begin
          tbl_d[tbl_wr_adr] = tbl_wr_data;
        end
        if (start) begin
          err_d  = 1'b0;
          fcnt_d = '0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_ACCUM;
          end else begin
            result_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        acc_load_ena  = 1'b0;
        acc_trunc_ena = 1'b1;
        term_ready    = 1'b1;
        if (term_valid) begin
          acc_in_a = term_data;
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        acc_load_ena  = 1'b0;
        acc_trunc_ena = 1'b1;
        // m >= 2^(MOD_W-1) keeps lo below 2m, so a single subtract fully reduces.
        if (acc_hi == 3'd0) begin
          result_d = (acc_lo >= modulus) ? (acc_lo - modulus) : acc_lo;
          state_d  = S_DONE;
        end else if (fcnt_q == 2'd3) begin
          err_d    = 1'b1;
          result_d = acc_lo;
          state_d  = S_DONE;
        end else begin
          fcnt_d = fcnt_q + 2'd1;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign acc_in_b = acc_trunc_ena ? tbl_q[acc_trunc_adr] : '0;
  assign result   = result_q;
  assign err      = err_q;

endmodule

// File: tb/tb_modaccum_trunc_ctrl.sv
// Directed bench for modaccum_trunc_ctrl with a behavioural 21-bit folding accumulator.
module tb_modaccum_trunc_ctrl;

  localparam int MOD_W   = 18;
  localparam int TRUNC_W = 3;
  localparam int LEN_W   = 8;
  localparam logic [MOD_W-1:0] M = 18'd262139;

  logic               clk;
  logic               reset;
  logic [MOD_W-1:0]   modulus;
  logic               tbl_wr_ena;
  logic [TRUNC_W-1:0] tbl_wr_adr;
  logic [MOD_W-1:0]   tbl_wr_data;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               busy;
  logic               term_valid;
  logic [MOD_W:0]     term_data;
  logic               term_ready;
  logic               acc_load_ena;
  logic               acc_trunc_ena;
  logic [MOD_W:0]     acc_in_a;
  logic [MOD_W-1:0]   acc_in_b;
  logic [TRUNC_W-1:0] acc_trunc_adr;
  logic [MOD_W+2:0]   acc_result;
  logic [MOD_W-1:0]   result;
  logic               result_valid;
  logic               result_ready;
  logic               err;

  int checks = 0;
  int passed = 0;

  modaccum_trunc_ctrl #(.MOD_W(MOD_W), .TRUNC_W(TRUNC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .modulus(modulus),
    .tbl_wr_ena(tbl_wr_ena), .tbl_wr_adr(tbl_wr_adr), .tbl_wr_data(tbl_wr_data),
    .start(start), .len(len), .busy(busy),
    .term_valid(term_valid), .term_data(term_data), .term_ready(term_ready),
    .acc_load_ena(acc_load_ena), .acc_trunc_ena(acc_trunc_ena),
    .acc_in_a(acc_in_a), .acc_in_b(acc_in_b),
    .acc_trunc_adr(acc_trunc_adr), .acc_result(acc_result),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: fold replaces the high bits by the table correction.
  // fold_off models an accumulator whose high bits never clear.
  logic [20:0] acc;
  logic        fold_off;
  always @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else if (acc_load_ena) acc <= 21'(acc_in_a);
    else if (acc_trunc_ena) begin
      if (fold_off) acc <= acc + 21'(acc_in_a) + 21'(acc_in_b);
      else          acc <= 21'(acc[17:0]) + 21'(acc_in_a) + 21'(acc_in_b);
    end
  end
  assign acc_result    = acc;
  assign acc_trunc_adr = acc[20:18];

  task automatic program_table();
    for (int k = 0; k < 8; k++) begin
      tbl_wr_ena  = 1'b1;
      tbl_wr_adr  = TRUNC_W'(k);
      tbl_wr_data = MOD_W'(5 * k);
      @(negedge clk);
    end
    tbl_wr_ena = 1'b0;
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_term(input int d);
    int n = 0;
    term_valid = 1'b1;
    term_data  = (MOD_W+1)'(d);
    while (!term_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    term_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    term_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!result_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, term_ready, acc_load_ena, acc_trunc_ena, result_valid, err} !== 6'b001000)
      $display("FAIL reset_ctl: got %b want 001000",
               {busy, term_ready, acc_load_ena, acc_trunc_ena, result_valid, err});
    else passed++;
    checks++;
    if (acc_in_a !== '0 || acc_in_b !== '0)
      $display("FAIL reset_acc_in: got a=%0d b=%0d want 0 0", acc_in_a, acc_in_b);
    else passed++;
    checks++;
    if (result !== '0) $display("FAIL reset_result: got %0d want 0", result);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    program_table();
  endtask

  task automatic test_single();
    int cyc;
    start_job(1);
    send_term(10);
    wait_valid(10, cyc);
    checks++;
    if (2 + cyc !== 3) $display("FAIL single_latency: got %0d want 3", 2 + cyc);
    else passed++;
    checks++;
    if (result !== 18'd10) $display("FAIL single_result: got %0d want 10", result);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err);
    else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_job(3);
    for (int i = 0; i < 3; i++) send_term(524287);
    wait_valid(10, cyc);
    checks++;
    if (cyc !== 2) $display("FAIL b2b_flush_cycles: got %0d want 2", cyc);
    else passed++;
    checks++;
    if (result !== 18'd27) $display("FAIL b2b_result: got %0d want 27", result);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL b2b_err: got %b want 0", err);
    else passed++;
    handshake();
  endtask

  task automatic test_final_sub();
    int cyc;
    start_job(1);
    send_term(262139);
    wait_valid(10, cyc);
    checks++;
    if (result_valid !== 1'b1 || result !== 18'd0)
      $display("FAIL final_sub: got v=%b r=%0d want v=1 r=0", result_valid, result);
    else passed++;
    handshake();
  endtask

  task automatic test_len_zero();
    checks++;
    if (busy !== 1'b0 || term_ready !== 1'b0)
      $display("FAIL len0_idle: got busy=%b tr=%b want 0 0", busy, term_ready);
    else passed++;
    start_job(0);
    checks++;
    if (result_valid !== 1'b1 || result !== 18'd0)
      $display("FAIL len0_result: got v=%b r=%0d want v=1 r=0", result_valid, result);
    else passed++;
    checks++;
    if (term_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL len0_ctl: got tr=%b busy=%b want 0 1", term_ready, busy);
    else passed++;
    handshake();
  endtask

  task automatic test_stall_and_ignore();
    int cyc;
    start_job(4);
    send_term(100000);
    bubble(2);
    send_term(200000);
    bubble(1);
    send_term(300000);
    bubble(3);
    send_term(400000);
    wait_valid(10, cyc);
    // 1000000 mod 262139 = 213583
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result_valid !== 1'b1 || result !== 18'd213583)
        $display("FAIL stall_hold%0d: got v=%b r=%0d want v=1 r=213583", i, result_valid, result);
      else passed++;
      start      = (i == 1);
      len        = 8'd7;
      tbl_wr_ena = (i == 2);
      tbl_wr_adr = 3'd1;
      tbl_wr_data = 18'd999;
      @(negedge clk);
    end
    start      = 1'b0;
    tbl_wr_ena = 1'b0;
    handshake();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL stall_idle: got busy=%b v=%b want 0 0", busy, result_valid);
    else passed++;
    start_job(1);
    send_term(524287);
    wait_valid(10, cyc);
    checks++;
    if (result !== 18'd9) $display("FAIL stall_tbl_kept: got %0d want 9", result);
    else passed++;
    handshake();
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    start_job(3);
    send_term(100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, term_ready, acc_load_ena, acc_trunc_ena, result_valid, err} !== 6'b001000)
      $display("FAIL midrst_ctl: got %b want 001000",
               {busy, term_ready, acc_load_ena, acc_trunc_ena, result_valid, err});
    else passed++;
    @(negedge clk);
    reset    = 1'b0;
    fold_off = 1'b1;
    @(negedge clk);
    start_job(1);
    send_term(524287);
    checks++;
    if (acc_trunc_adr !== 3'd1 || acc_in_b !== '0)
      $display("FAIL midrst_tbl_clear: got adr=%0d b=%0d want 1 0", acc_trunc_adr, acc_in_b);
    else passed++;
    wait_valid(10, cyc);
    checks++;
    if (cyc !== 4) $display("FAIL timeout_flush_cycles: got %0d want 4", cyc);
    else passed++;
    checks++;
    if (err !== 1'b1 || result !== 18'd262143)
      $display("FAIL timeout_err: got err=%b r=%0d want 1 262143", err, result);
    else passed++;
    handshake();
    fold_off = 1'b0;
    start_job(0);
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err);
    else passed++;
    handshake();
  endtask

  initial begin
    reset        = 1'b1;
    fold_off     = 1'b0;
    modulus      = M;
    tbl_wr_ena   = 1'b0;
    tbl_wr_adr   = '0;
    tbl_wr_data  = '0;
    start        = 1'b0;
    len          = '0;
    term_valid   = 1'b0;
    term_data    = '0;
    result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_final_sub();
    test_len_zero();
    test_stall_and_ignore();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
